// File: rtl/alu_datapath_p.sv
// Accumulator datapath: ALU with carry/zero flags, register file and a
// multi-cycle shift-add multiplier behind a valid/ready handshake.
module alu_datapath_p #(
   parameter  int WIDTH    = 8,
   parameter  int NUM_REGS = 4,
   localparam int RA_W     = $clog2(NUM_REGS)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [3:0]       i_op,
   input  logic             i_src_mem,
   input  logic [RA_W-1:0]  i_rf_raddr,
   input  logic             i_rf_we,
   input  logic [RA_W-1:0]  i_rf_waddr,
   input  logic [WIDTH-1:0] i_register_file,
   input  logic [WIDTH-1:0] i_data_memory,
   input  logic             i_direct_load,
   input  logic [WIDTH-1:0] i_direct_data,
   output logic [WIDTH-1:0] o_alu,
   output logic [WIDTH-1:0] o_alu_argument,
   output logic [WIDTH-1:0] o_register_file,
   output logic [WIDTH-1:0] o_acumulator,
   output logic [WIDTH-1:0] o_mul_high,
   output logic             o_carry,
   output logic             o_zero,
   output logic             o_busy,
   output logic             o_done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3,
      OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_LD  = 4'd6,  OP_ADC = 4'd7,
      OP_SBB = 4'd8,  OP_SHL = 4'd9,  OP_SHR = 4'd10, OP_MUL = 4'd11
   } op_e;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rf [1:NUM_REGS-1];
   logic [WIDTH-1:0] acc_q, mul_high_q, mcand_q, mhi_q, mlo_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, zero_q, done_q;

   logic [WIDTH-1:0] operand, rf_rdata, alu_res, step_hi, step_lo;
   logic [WIDTH:0]   sum, mac;
   logic             alu_carry, accept, start_mul, alu_wr, mul_last;

   // Register file read: entry 0 is an external value, out-of-range reads give 0
   always_comb begin
      rf_rdata = '0;
      if (i_rf_raddr == '0)
         rf_rdata = i_register_file;
      else if (int'(i_rf_raddr) < NUM_REGS)
         rf_rdata = rf[i_rf_raddr];
   end

   assign operand = i_src_mem ? i_data_memory : rf_rdata;

   always_comb begin
      sum       = '0;
      alu_res   = acc_q;
      alu_carry = carry_q;
      case (i_op)
         OP_ADD: begin
            sum = {1'b0, acc_q} + {1'b0, operand};
            alu_res = sum[WIDTH-1:0]; alu_carry = sum[WIDTH];
         end
         OP_SUB: begin
            sum = {1'b0, acc_q} - {1'b0, operand};
            alu_res = sum[WIDTH-1:0]; alu_carry = sum[WIDTH];
         end
         OP_AND: begin alu_res = acc_q & operand; alu_carry = 1'b0; end
         OP_OR:  begin alu_res = acc_q | operand; alu_carry = 1'b0; end
         OP_XOR: begin alu_res = acc_q ^ operand; alu_carry = 1'b0; end
         OP_NOT: begin alu_res = ~operand;        alu_carry = 1'b0; end
         OP_LD:  begin alu_res = operand;         alu_carry = 1'b0; end
         OP_ADC: begin
            sum = {1'b0, acc_q} + {1'b0, operand} + {{WIDTH{1'b0}}, carry_q};
            alu_res = sum[WIDTH-1:0]; alu_carry = sum[WIDTH];
         end
         OP_SBB: begin
            // A-B-c never drops below -2^WIDTH, so the extra bit is the borrow
            sum = {1'b0, acc_q} - {1'b0, operand} - {{WIDTH{1'b0}}, carry_q};
            alu_res = sum[WIDTH-1:0]; alu_carry = sum[WIDTH];
         end
         OP_SHL: begin alu_res = {acc_q[WIDTH-2:0], 1'b0}; alu_carry = acc_q[WIDTH-1]; end
         OP_SHR: begin alu_res = {1'b0, acc_q[WIDTH-1:1]}; alu_carry = acc_q[0]; end
         default: ;
      endcase
   end

   assign o_ready   = (state_q == S_IDLE);
   assign accept    = i_valid && o_ready;
   assign start_mul = accept && !i_direct_load && (i_op == OP_MUL);
   assign alu_wr    = accept && !i_direct_load && (i_op <= OP_SHR);
   assign mul_last  = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));

   // One shift-add iteration: add multiplicand on multiplier LSB, shift pair right
   assign mac     = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, mcand_q} : '0);
   assign step_hi = mac[WIDTH:1];
   assign step_lo = {mac[0], mlo_q[WIDTH-1:1]};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_mul) state_d = S_RUN;
         S_RUN:  if (mul_last)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_q      <= '0;
         mul_high_q <= '0;
         mcand_q    <= '0;
         mhi_q      <= '0;
         mlo_q      <= '0;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         zero_q     <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_mul) begin
            mcand_q <= acc_q;
            mlo_q   <= operand;
            mhi_q   <= '0;
            cnt_q   <= '0;
         end else if (state_q == S_RUN) begin
            mhi_q <= step_hi;
            mlo_q <= step_lo;
            cnt_q <= cnt_q + 1'b1;
            if (mul_last) begin
               acc_q      <= step_lo;
               mul_high_q <= step_hi;
               carry_q    <= |step_hi;
               zero_q     <= ~|step_lo;
               done_q     <= 1'b1;
            end
         end else if (accept) begin
            done_q <= 1'b1;
            if (i_direct_load) begin
               acc_q  <= i_direct_data;
               zero_q <= (i_direct_data == '0);
            end else if (alu_wr) begin
               acc_q   <= alu_res;
               carry_q <= alu_carry;
               zero_q  <= (alu_res == '0);
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (i_rf_we && (i_rf_waddr != '0) && (int'(i_rf_waddr) < NUM_REGS)) begin
         rf[i_rf_waddr] <= acc_q;
      end
   end

   assign o_alu           = alu_res;
   assign o_alu_argument  = operand;
   assign o_register_file = rf_rdata;
   assign o_acumulator    = acc_q;
   assign o_mul_high      = mul_high_q;
   assign o_carry         = carry_q;
   assign o_zero          = zero_q;
   assign o_busy          = (state_q == S_RUN);
   assign o_done          = done_q;

endmodule

// File: tb/tb_alu_datapath_p.sv
// Scoreboard bench for alu_datapath_p: arithmetic reference model feeds an
// expectation queue that a negedge monitor drains on every o_done pulse.
module tb_alu_datapath_p;
   localparam int W = 8;
   localparam int M = 256;

   logic         i_clk = 1'b0, i_rst_n = 1'b0;
   logic         i_valid = 1'b0, i_src_mem = 1'b1, i_rf_we = 1'b0, i_direct_load = 1'b0;
   logic [3:0]   i_op = '0;
   logic [1:0]   i_rf_raddr = '0, i_rf_waddr = '0;
   logic [W-1:0] i_register_file = '0, i_data_memory = '0, i_direct_data = '0;
   logic [W-1:0] o_alu, o_alu_argument, o_register_file, o_acumulator, o_mul_high;
   logic         o_ready, o_carry, o_zero, o_busy, o_done;

   alu_datapath_p #(.WIDTH(W), .NUM_REGS(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_src_mem(i_src_mem), .i_rf_raddr(i_rf_raddr), .i_rf_we(i_rf_we),
      .i_rf_waddr(i_rf_waddr), .i_register_file(i_register_file),
      .i_data_memory(i_data_memory), .i_direct_load(i_direct_load),
      .i_direct_data(i_direct_data), .o_alu(o_alu), .o_alu_argument(o_alu_argument),
      .o_register_file(o_register_file), .o_acumulator(o_acumulator),
      .o_mul_high(o_mul_high), .o_carry(o_carry), .o_zero(o_zero),
      .o_busy(o_busy), .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   typedef struct { int acc; int hi; int c; int z; } exp_t;
   exp_t exp_q[$];
   int n_checks = 0, n_fail = 0;
   int m_acc, m_hi, m_c, m_z;
   int m_rf [4];

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_hi = 0; m_c = 0; m_z = 1;
      foreach (m_rf[i]) m_rf[i] = 0;
      exp_q.delete();
   endtask

   function automatic void alu_ref(input int op, input int a, input int b, input int c,
                                   output int r, output int co);
      co = 0;
      case (op)
         0:  begin r = (a + b) % M;          co = (a + b) >= M; end
         1:  begin r = (a - b + M) % M;      co = a < b; end
         2:  r = a & b;
         3:  r = a | b;
         4:  r = a ^ b;
         5:  r = (M - 1) - b;
         6:  r = b;
         7:  begin r = (a + b + c) % M;      co = (a + b + c) >= M; end
         8:  begin r = (a - b - c + 2*M) % M; co = a < (b + c); end
         9:  begin r = (a * 2) % M;          co = a >= M/2; end
         10: begin r = a / 2;                co = a % 2; end
         default: begin r = a; co = c; end
      endcase
   endfunction

   // Issue one operation; holds i_valid until accepted and updates the model at acceptance
   task automatic issue(input int op, input bit src, input int val, input int ra,
                        input bit dl, input int dd, input bit we, input int wa,
                        output int waits);
      int b, r, co, p;
      exp_t e;
      waits = 0;
      @(negedge i_clk);
      i_valid = 1'b1; i_op = 4'(op); i_src_mem = src; i_data_memory = W'(val);
      i_register_file = W'(val ^ 'hA5); i_rf_raddr = 2'(ra); i_direct_load = dl;
      i_direct_data = W'(dd); i_rf_we = 1'b0; i_rf_waddr = 2'(wa);
      while (o_ready !== 1'b1 && waits < 40) begin
         waits++;
         @(negedge i_clk);
      end
      if (o_ready !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL ready_timeout: o_ready=%b, expected 1 within 40 cycles", o_ready);
      end
      i_rf_we = we;
      #1;
      b = src ? val : (ra == 0 ? (val ^ 'hA5) : m_rf[ra]);
      alu_ref(op, m_acc, b, m_c, r, co);
      check("operand", int'(o_alu_argument), b);
      if (op <= 10) check($sformatf("alu_op%0d", op), int'(o_alu), r);
      if (we && wa != 0) m_rf[wa] = m_acc;
      if (dl) begin
         m_acc = dd; m_z = (dd == 0);
      end else if (op <= 10) begin
         m_acc = r; m_c = co; m_z = (r == 0);
      end else if (op == 11) begin
         p = m_acc * b; m_acc = p % M; m_hi = p / M; m_c = (m_hi != 0); m_z = (m_acc == 0);
      end
      e.acc = m_acc; e.hi = m_hi; e.c = m_c; e.z = m_z;
      exp_q.push_back(e);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0; i_rf_we = 1'b0;
   endtask

   task automatic expect_state(input string tag, input int acc, input int c, input int z);
      check({tag, "_acc"},   int'(o_acumulator), acc);
      check({tag, "_carry"}, int'(o_carry), c);
      check({tag, "_zero"},  int'(o_zero), z);
   endtask

   task automatic reset_mid_cycle(input string tag);
      @(negedge i_clk);
      #2;
      i_rst_n = 1'b0;
      i_rf_raddr = 2'd1;
      #1;
      model_reset();
      expect_state(tag, 0, 0, 1);
      check({tag, "_mulhi"}, int'(o_mul_high), 0);
      check({tag, "_busy"},  int'(o_busy), 0);
      check({tag, "_ready"}, int'(o_ready), 1);
      check({tag, "_done"},  int'(o_done), 0);
      check({tag, "_rf1"},   int'(o_register_file), 0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   // Monitor: every retired operation must match the oldest expectation
   always @(negedge i_clk) begin
      if (i_rst_n === 1'b1 && o_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_done: o_done=1, expected no retirement pending");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ret_acc",   int'(o_acumulator), e.acc);
            check("ret_mulhi", int'(o_mul_high), e.hi);
            check("ret_carry", int'(o_carry), e.c);
            check("ret_zero",  int'(o_zero), e.z);
         end
      end
   end

   initial begin
      int w;
      model_reset();
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;

      // Carry chain
      issue(6, 1, 0, 0, 1, 'hF0, 0, 0, w);
      issue(0, 1, 'h20, 0, 0, 0, 0, 0, w);  expect_state("add", 'h10, 1, 0);
      issue(7, 1, 'h00, 0, 0, 0, 0, 0, w);  expect_state("adc", 'h11, 0, 0);
      issue(1, 1, 'h12, 0, 0, 0, 0, 0, w);  expect_state("sub", 'hFF, 1, 0);

      reset_mid_cycle("rst");

      // Shifts
      issue(6, 1, 0, 0, 1, 'h81, 0, 0, w);
      issue(9, 1, 0, 0, 0, 0, 0, 0, w);     expect_state("shl",  'h02, 1, 0);
      issue(10, 1, 0, 0, 0, 0, 0, 0, w);    expect_state("shr1", 'h01, 0, 0);
      issue(10, 1, 0, 0, 0, 0, 0, 0, w);    expect_state("shr2", 'h00, 1, 1);

      // Multiply 0xFF*0xFF with a NOP held against the busy datapath
      issue(6, 1, 0, 0, 1, 'hFF, 0, 0, w);
      issue(11, 1, 'hFF, 0, 0, 0, 0, 0, w);
      check("mul_busy", int'(o_busy), 1);
      check("mul_ready", int'(o_ready), 0);
      issue(12, 1, 0, 0, 0, 0, 0, 0, w);
      check("mul_wait_cycles", w, W);
      expect_state("mul", 'h01, 1, 0);
      check("mul_hi", int'(o_mul_high), 'hFE);

      // Register file: read-during-write returns old data; entry 0 is external
      reset_mid_cycle("rst2");
      issue(6, 1, 0, 0, 1, 'h5A, 0, 0, w);
      @(negedge i_clk);
      i_rf_we = 1'b1; i_rf_waddr = 2'd3; i_rf_raddr = 2'd3;
      #1 check("rf_rdw_old", int'(o_register_file), 'h00);
      @(posedge i_clk);
      #1 check("rf_rdw_new", int'(o_register_file), 'h5A);
      m_rf[3] = 'h5A;
      @(negedge i_clk);
      i_rf_we = 1'b1; i_rf_waddr = 2'd0; i_rf_raddr = 2'd0; i_register_file = 'h3C;
      @(posedge i_clk);
      #1 check("rf_entry0", int'(o_register_file), 'h3C);
      i_rf_we = 1'b0; i_rf_raddr = 2'd3;
      #1 check("rf_entry3_kept", int'(o_register_file), 'h5A);

      // Abort a multiply with reset
      issue(11, 1, 'h37, 0, 0, 0, 0, 0, w);
      repeat (2) @(posedge i_clk);
      reset_mid_cycle("abort");
      issue(0, 1, 'h07, 0, 0, 0, 0, 0, w);  expect_state("post_abort", 'h07, 0, 0);

      // Randomised traffic against the reference model
      for (int n = 0; n < 200; n++) begin
         issue($urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, M-1),
               $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom_range(0, M-1),
               1'($urandom_range(0, 1)), $urandom_range(0, 3), w);
      end

      for (int k = 0; k < 40 && exp_q.size() > 0; k++) @(negedge i_clk);
      if (exp_q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL drain: %0d retirements outstanding, expected 0", exp_q.size());
      end
      repeat (2) @(negedge i_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
